// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and variable-latency
// LSU/divider results onto the single register file write port. LSU results
// that lose to the ALU are parked in a small circular FIFO, and a per-register
// scoreboard tracks destinations with an outstanding long-latency write.
module wb_arbiter #(
    parameter int DEPTH = 4  // power of two, at least 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        lsu_issue_i,
    input  logic [4:0]  lsu_issue_rd_i,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_ready_o,
    output logic        rd_wren_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic [31:0] busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 37;  // {rd[4:0], data[31:0]}

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [31:0]   busy_reg;
    logic [31:0]   busy_next;
    logic [31:0]   set_hit;
    logic [31:0]   clr_hit;
    logic [EW-1:0] head;
    logic          lsu_hs;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          sel_write;
    logic          sel_lsu;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;

    // Ready comes only from the registered count: a full FIFO never passes
    // an LSU result straight through, even when it is popping this cycle.
    assign lsu_ready_o = (count_reg < CW'(DEPTH));
    assign lsu_hs      = lsu_valid_i && lsu_ready_o;
    assign fifo_empty  = (count_reg == '0);
    assign head        = mem[rptr_reg];
    assign busy_o      = busy_reg;

    // Pick this cycle's writer: ALU first, then the FIFO head, then a direct LSU result.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        sel_write = 1'b0;
        sel_lsu   = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_valid_i) begin
            sel_write = 1'b1;
            sel_rd    = alu_rd_i;
            sel_data  = alu_data_i;
            push      = lsu_hs;
        end else if (!fifo_empty) begin
            sel_write = 1'b1;
            sel_lsu   = 1'b1;
            sel_rd    = head[36:32];
            sel_data  = head[31:0];
            pop       = 1'b1;
            push      = lsu_hs;
        end else if (lsu_hs) begin
            sel_write = 1'b1;
            sel_lsu   = 1'b1;
            sel_rd    = lsu_rd_i;
            sel_data  = lsu_data_i;
        end
    end

    // Occupancy: unchanged on simultaneous push and pop.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Scoreboard bit update; an issue to the same register beats the clear.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_busy
            assign set_hit[gi]   = (gi != 0) && lsu_issue_i && (lsu_issue_rd_i == 5'(gi));
            assign clr_hit[gi]   = sel_lsu && (sel_rd == 5'(gi));
            assign busy_next[gi] = set_hit[gi] | (busy_reg[gi] & ~clr_hit[gi]);
        end
    endgenerate

    // FIFO storage array; contents need no reset because count guards every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_reg] <= {lsu_rd_i, lsu_data_i};
        end
    end

    // Pointers, count, scoreboard and the registered write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            busy_reg  <= '0;
            rd_wren_o <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            count_reg <= count_next;
            busy_reg  <= busy_next;
            // x0 results are consumed but never reach the register file.
            rd_wren_o <= sel_write && (sel_rd != 5'd0);
            if (sel_write) begin
                rd_addr_o <= sel_rd;
                rd_data_o <= sel_data;
            end
        end
    end

    // Decode-side hazard contract.
    a_issue_not_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lsu_issue_i && lsu_issue_rd_i != 5'd0) |-> !busy_reg[lsu_issue_rd_i]);
    a_alu_not_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (alu_valid_i && alu_rd_i != 5'd0) |-> !busy_reg[alu_rd_i]);
    a_lsu_is_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lsu_valid_i && lsu_rd_i != 5'd0) |-> busy_reg[lsu_rd_i]);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model; expected writes go into a scoreboard queue
// that a posedge monitor drains and compares.
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        lsu_issue_i = 1'b0;
    logic [4:0]  lsu_issue_rd_i = '0;
    logic        lsu_valid_i = 1'b0;
    logic [4:0]  lsu_rd_i = '0;
    logic [31:0] lsu_data_i = '0;
    logic        lsu_ready_o;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [31:0] busy_o;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_issue_i(lsu_issue_i), .lsu_issue_rd_i(lsu_issue_rd_i),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .lsu_ready_o(lsu_ready_o), .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o),
        .rd_data_o(rd_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [4:0] rd; logic [31:0] data;} ent_t;
    typedef struct {logic [4:0] rd; logic [31:0] data; int due;} exp_t;

    ent_t        fq[$];       // model of accepted-but-unwritten LSU results
    exp_t        exp_q[$];    // scoreboard of register file writes
    logic [31:0] m_busy = '0; // model scoreboard
    int          edge_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: pop and compare whenever the DUT presents a write.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        while (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
            e = exp_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_write: x%0d=0x%0h never written, expected at edge %0d", e.rd, e.data, e.due);
        end
        if (rd_wren_o) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got x%0d=0x%0h, expected no write", rd_addr_o, rd_data_o);
            end else begin
                e = exp_q.pop_front();
                $display("write x%0d = 0x%08h at edge %0d", rd_addr_o, rd_data_o, edge_cnt);
                check("wr_addr", 32'(rd_addr_o), 32'(e.rd));
                check("wr_data", rd_data_o, e.data);
                check("wr_edge", edge_cnt, e.due);
            end
        end
        check("busy", busy_o, m_busy);
    end

    // Drive one cycle of inputs at the negedge and advance the reference model.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic iv, input logic [4:0] ird,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         output logic acc);
        logic        ready_m;
        logic        w;
        logic        lsrc;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        ent_t        e;
        @(negedge clk);
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = adat;
        lsu_issue_i = iv; lsu_issue_rd_i = ird;
        lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ldat;
        ready_m = (fq.size() < DEPTH);
        check("lsu_ready", 32'(lsu_ready_o), 32'(ready_m));
        acc  = lv && ready_m;
        w    = 1'b0;
        lsrc = 1'b0;
        wrd  = '0;
        wdat = '0;
        if (av) begin
            w = 1'b1; wrd = ard; wdat = adat;
            if (acc) fq.push_back('{lrd, ldat});
        end else if (fq.size() > 0) begin
            e = fq.pop_front();
            w = 1'b1; lsrc = 1'b1; wrd = e.rd; wdat = e.data;
            if (acc) fq.push_back('{lrd, ldat});
        end else if (acc) begin
            w = 1'b1; lsrc = 1'b1; wrd = lrd; wdat = ldat;
        end
        if (w && wrd != 5'd0) exp_q.push_back('{wrd, wdat, edge_cnt + 1});
        if (lsrc && wrd != 5'd0) m_busy[wrd] = 1'b0;
        if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    task automatic issue_range(input int a, input int b);
        logic acc;
        for (int r = a; r <= b; r++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0, 5'd0, 32'd0, acc);
    endtask

    // LSU presents rd first..last back to back; ALU writes x1.. for alu_n cycles.
    task automatic run_lsu_seq(input int first, input int last, input int alu_n);
        logic acc;
        int   nxt;
        nxt = first;
        for (int k = 0; k < 40 && (nxt <= last || k < alu_n); k++) begin
            cycle(k < alu_n, 5'(k + 1), 32'h100 + 32'(k), 1'b0, 5'd0,
                  nxt <= last, 5'(nxt), 32'hD000_0000 + 32'(nxt), acc);
            if (acc) nxt++;
        end
        check("seq_all_accepted", 32'(nxt), 32'(last + 1));
        idle(8);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic        acc;
        logic        av, iv, hold;
        logic [4:0]  ard, ird, lrd_h;
        logic [31:0] adat, ldat_h;
        logic [4:0]  pending[$];
        int          idx;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("rst_wren", 32'(rd_wren_o), 32'd0);
        check("rst_addr", 32'(rd_addr_o), 32'd0);
        check("rst_data", rd_data_o, 32'd0);
        check("rst_ready", 32'(lsu_ready_o), 32'd1);

        // ALU write x3 = 0x11
        cycle(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, acc);
        idle(2);

        // Issue x5, result 3 cycles later with the ALU idle
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, acc);
        #6;
        check("issue_busy5", 32'(busy_o[5]), 32'd1);
        idle(2);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD, acc);
        #6;
        check("direct_wren", 32'(rd_wren_o), 32'd1);
        check("direct_busy5", 32'(busy_o[5]), 32'd0);
        idle(2);

        // ALU burst x1..x6 versus LSU x8..x12: FIFO fills, then drains in order
        issue_range(8, 12);
        run_lsu_seq(8, 12, 6);

        // Count held at 2 with simultaneous push/pop for 10 cycles
        issue_range(13, 24);
        run_lsu_seq(13, 24, 2);

        // LSU result to x0: handshake completes, no write
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hBAD0, acc);
        check("x0_direct_acc", 32'(acc), 32'd1);
        cycle(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 5'd0, 32'hBAD1, acc);
        check("x0_push_acc", 32'(acc), 32'd1);
        idle(3);

        // Reset with 3 FIFO entries and busy = x5|x8
        issue_range(5, 5);
        issue_range(8, 8);
        cycle(1'b1, 5'd1, 32'h31, 1'b0, 5'd0, 1'b1, 5'd5, 32'h55, acc);
        cycle(1'b1, 5'd1, 32'h32, 1'b0, 5'd0, 1'b1, 5'd8, 32'h88, acc);
        cycle(1'b1, 5'd1, 32'h33, 1'b0, 5'd0, 1'b1, 5'd0, 32'h00, acc);
        #6;
        check("pre_rst_busy", busy_o, 32'h0000_0120);
        check("pre_rst_ready", 32'(lsu_ready_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        alu_valid_i = 1'b0; lsu_issue_i = 1'b0; lsu_valid_i = 1'b0;
        fq.delete();
        exp_q.delete();
        m_busy = '0;
        #1;
        check("arst_wren", 32'(rd_wren_o), 32'd0);
        check("arst_addr", 32'(rd_addr_o), 32'd0);
        check("arst_data", rd_data_o, 32'd0);
        check("arst_busy", busy_o, 32'd0);
        check("arst_ready", 32'(lsu_ready_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        idle(5);

        // Random traffic honouring the decode hazard contract
        hold = 1'b0; lrd_h = '0; ldat_h = '0;
        for (int k = 0; k < 1500; k++) begin
            av = ($urandom_range(0, 99) < 45);
            do ard = 5'($urandom_range(0, 31)); while (m_busy[ard]);
            adat = $urandom;
            if (!hold) begin
                if (pending.size() > 0 && $urandom_range(0, 99) < 50) begin
                    idx = $urandom_range(0, pending.size() - 1);
                    lrd_h = pending[idx];
                    pending.delete(idx);
                    ldat_h = $urandom;
                    hold = 1'b1;
                end else if ($urandom_range(0, 99) < 3) begin
                    lrd_h = 5'd0;
                    ldat_h = $urandom;
                    hold = 1'b1;
                end
            end
            iv = ($countones(m_busy) < 10) && ($urandom_range(0, 99) < 30);
            ird = '0;
            if (iv) begin
                do ird = 5'($urandom_range(1, 31)); while (m_busy[ird] || (av && ird == ard));
            end
            cycle(av, ard, adat, iv, ird, hold, lrd_h, ldat_h, acc);
            if (iv) pending.push_back(ird);
            if (acc) hold = 1'b0;
        end

        // Drain everything still outstanding
        for (int k = 0; k < 500 && (pending.size() > 0 || hold || fq.size() > 0); k++) begin
            if (!hold && pending.size() > 0) begin
                lrd_h = pending.pop_front();
                ldat_h = $urandom;
                hold = 1'b1;
            end
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, hold, lrd_h, ldat_h, acc);
            if (acc) hold = 1'b0;
        end
        idle(4);
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("drain_busy_clear", busy_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
